// File: rtl/fetch_req_ctrl.sv
// Instruction-memory request controller: issues sequential word fetches on the req/gnt/rvalid
// bus, tracks in-flight requests, drops stale responses after redirects and pushes the rest to the fetch FIFO.
module fetch_req_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int unsigned NUM_REQS = 2,
    parameter int unsigned CNT_W    = $clog2(NUM_REQS + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_addr_i,
    input  logic [CNT_W-1:0] fifo_free_i,
    output logic             out_valid_o,
    output logic [31:0]      out_rdata_o,
    output logic             out_err_o,
    output logic [31:0]      out_addr_o,
    output logic             instr_req_o,
    output logic [31:0]      instr_addr_o,
    input  logic             instr_gnt_i,
    input  logic             instr_rvalid_i,
    input  logic [31:0]      instr_rdata_i,
    input  logic             instr_err_i,
    output logic             busy_o
);

    localparam int unsigned PTR_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [31:0] PC_RESET_W = {PC_RESET[31:2], 2'b00};

    logic             in_reset_q;
    logic             req_hold_q, req_hold_d;
    logic [31:0]      fetch_addr_q, fetch_addr_d;
    logic             pend_redirect_q, pend_redirect_d;
    logic [31:0]      pend_addr_q, pend_addr_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      addr_q [NUM_REQS];

    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_rdata_q, out_rdata_d;
    logic             out_err_q, out_err_d;
    logic [31:0]      out_addr_q, out_addr_d;

    logic             can_issue;
    logic             fire;
    logic             rv_ok;
    logic             rv_out;
    logic             rv_disc;
    logic             push;
    logic [SUM_W-1:0] inflight;
    logic [CNT_W-1:0] out_after;
    logic [CNT_W-1:0] disc_after;
    logic [31:0]      redir_word;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^redirect_addr_i[1:0];
    assign redir_word       = {redirect_addr_i[31:2], 2'b00};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(NUM_REQS - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // A raised request stays up until granted, independent of credit or count changes.
    assign inflight     = SUM_W'(outstanding_q) + SUM_W'(discard_q);
    assign can_issue    = ~in_reset_q & (inflight < SUM_W'(NUM_REQS)) & (outstanding_q < fifo_free_i);
    assign instr_req_o  = req_hold_q | can_issue;
    assign instr_addr_o = fetch_addr_q;
    assign busy_o       = (outstanding_q != '0) | instr_req_o;

    assign fire    = instr_req_o & instr_gnt_i;
    assign rv_ok   = instr_rvalid_i & ~in_reset_q & (inflight != '0);
    assign rv_disc = rv_ok & (discard_q != '0);
    assign rv_out  = rv_ok & (discard_q == '0);
    assign push    = fire & ~redirect_i & ~pend_redirect_q;

    // Address generation and deferred redirect for a request caught mid-handshake
    always_comb begin
        fetch_addr_d    = fetch_addr_q;
        pend_redirect_d = pend_redirect_q;
        pend_addr_d     = pend_addr_q;
        req_hold_d      = instr_req_o & ~instr_gnt_i;
        if (fire) begin
            pend_redirect_d = 1'b0;
            if (redirect_i) begin
                fetch_addr_d = redir_word;
            end else if (pend_redirect_q) begin
                fetch_addr_d = pend_addr_q;
            end else begin
                fetch_addr_d = fetch_addr_q + 32'd4;
            end
        end else if (redirect_i) begin
            if (instr_req_o) begin
                pend_redirect_d = 1'b1;
                pend_addr_d     = redir_word;
            end else begin
                fetch_addr_d = redir_word;
            end
        end
    end

    // Outstanding/discard accounting; a redirect converts every live response into a discard
    always_comb begin
        out_after  = outstanding_q - CNT_W'(rv_out);
        disc_after = discard_q - CNT_W'(rv_disc);
        if (redirect_i) begin
            outstanding_d = '0;
            discard_d     = disc_after + out_after + CNT_W'(fire);
        end else begin
            outstanding_d = out_after + CNT_W'(fire & ~pend_redirect_q);
            discard_d     = disc_after + CNT_W'(fire & pend_redirect_q);
        end
    end

    // Address queue pointers; live entries are always younger than discarded ones
    always_comb begin
        rd_ptr_d = rv_out ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        if (redirect_i) begin
            wr_ptr_d = rd_ptr_d;
        end else if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
    end

    always_comb begin
        out_valid_d = rv_out & ~redirect_i;
        out_rdata_d = out_rdata_q;
        out_err_d   = out_err_q;
        out_addr_d  = out_addr_q;
        if (out_valid_d) begin
            out_rdata_d = instr_rdata_i;
            out_err_d   = instr_err_i;
            out_addr_d  = addr_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_reset_q      <= 1'b1;
            req_hold_q      <= 1'b0;
            fetch_addr_q    <= PC_RESET_W;
            pend_redirect_q <= 1'b0;
            pend_addr_q     <= '0;
            outstanding_q   <= '0;
            discard_q       <= '0;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            out_valid_q     <= 1'b0;
            out_rdata_q     <= '0;
            out_err_q       <= 1'b0;
            out_addr_q      <= '0;
        end else begin
            in_reset_q      <= 1'b0;
            req_hold_q      <= req_hold_d;
            fetch_addr_q    <= fetch_addr_d;
            pend_redirect_q <= pend_redirect_d;
            pend_addr_q     <= pend_addr_d;
            outstanding_q   <= outstanding_d;
            discard_q       <= discard_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            out_valid_q     <= out_valid_d;
            out_rdata_q     <= out_rdata_d;
            out_err_q       <= out_err_d;
            out_addr_q      <= out_addr_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(NUM_REQS); i++) begin
                addr_q[i] <= '0;
            end
        end else if (push) begin
            addr_q[wr_ptr_q] <= fetch_addr_q;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_rdata_o = out_rdata_q;
    assign out_err_o   = out_err_q;
    assign out_addr_o  = out_addr_q;

    a_rvalid_legal: assert property (@(posedge clk) disable iff (!rstn || in_reset_q)
        instr_rvalid_i |-> (inflight != '0));

    a_count_bound: assert property (@(posedge clk) disable iff (!rstn)
        inflight <= SUM_W'(NUM_REQS));

    a_req_held: assert property (@(posedge clk) disable iff (!rstn)
        (instr_req_o && !instr_gnt_i) |=> (instr_req_o && $stable(instr_addr_o)));

endmodule

// File: tb/tb_fetch_req_ctrl.sv
// Randomized bench for fetch_req_ctrl: a bus/memory responder plus a transaction-level
// model of which fetches are live or stale and which address each new request must carry.
module tb_fetch_req_ctrl;

    localparam int unsigned N   = 2;
    localparam int unsigned CW  = 2;
    localparam logic [31:0] PCR = 32'h0000_0100;

    logic          clk = 1'b0;
    logic          rstn;
    logic          redirect_i;
    logic [31:0]   redirect_addr_i;
    logic [CW-1:0] fifo_free_i;
    logic          out_valid_o;
    logic [31:0]   out_rdata_o;
    logic          out_err_o;
    logic [31:0]   out_addr_o;
    logic          instr_req_o;
    logic [31:0]   instr_addr_o;
    logic          instr_gnt_i;
    logic          instr_rvalid_i;
    logic [31:0]   instr_rdata_i;
    logic          instr_err_i;
    logic          busy_o;

    fetch_req_ctrl #(.PC_RESET(PCR), .NUM_REQS(N)) dut (
        .clk(clk), .rstn(rstn),
        .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
        .fifo_free_i(fifo_free_i),
        .out_valid_o(out_valid_o), .out_rdata_o(out_rdata_o),
        .out_err_o(out_err_o), .out_addr_o(out_addr_o),
        .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
        .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
        .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } txn_t;

    txn_t        bus_q[$];
    bit          held_m;
    bit          req_stale;
    logic [31:0] held_addr;
    logic [31:0] model_next;
    bit          exp_v;
    logic [31:0] exp_d;
    logic [31:0] exp_a;
    bit          exp_e;
    int          total = 0;
    int          bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int live_cnt();
        int n = 0;
        foreach (bus_q[i]) if (!bus_q[i].stale) n++;
        return n;
    endfunction

    function automatic logic [31:0] rand_target();
        if ($urandom_range(3, 0) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
        return 32'($urandom_range(32'h7FF, 0));
    endfunction

    task automatic model_reset();
        bus_q.delete();
        held_m     = 1'b0;
        req_stale  = 1'b0;
        held_addr  = '0;
        exp_v      = 1'b0;
        model_next = {PCR[31:2], 2'b00};
    endtask

    // One bus cycle: check last cycle's push, drive inputs, check request side, advance model.
    task automatic step(input int pg, input int prv, input int prd, input int fmin, input int fmax);
        bit          exp_req;
        bit          rv;
        logic [31:0] cur_addr;
        txn_t        t;
        @(negedge clk);
        check_val("out_valid", 32'(out_valid_o), 32'(exp_v));
        if (exp_v) begin
            check_val("out_rdata", out_rdata_o, exp_d);
            check_val("out_err", 32'(out_err_o), 32'(exp_e));
            check_val("out_addr", out_addr_o, exp_a);
        end
        fifo_free_i     = CW'($urandom_range(fmax, fmin));
        redirect_i      = ($urandom_range(99, 0) < prd);
        redirect_addr_i = rand_target();
        rv              = (bus_q.size() != 0) && ($urandom_range(99, 0) < prv);
        instr_rvalid_i  = rv;
        instr_rdata_i   = $urandom;
        instr_err_i     = ($urandom_range(3, 0) == 0);
        instr_gnt_i     = ($urandom_range(99, 0) < pg);
        #1;
        exp_req = held_m || ((bus_q.size() < N) && (live_cnt() < int'(fifo_free_i)));
        check_val("req", 32'(instr_req_o), 32'(exp_req));
        check_val("busy", 32'(busy_o), 32'((live_cnt() != 0) || exp_req));
        check_val("inflight_bound", 32'(bus_q.size() <= N), 32'd1);
        if (exp_req) begin
            cur_addr = held_m ? held_addr : model_next;
            check_val(held_m ? "addr_hold" : "addr", instr_addr_o, cur_addr);
            if (!held_m) req_stale = 1'b0;
            held_addr = cur_addr;
        end
        exp_v = 1'b0;
        if (rv) begin
            t = bus_q.pop_front();
            if (!t.stale && !redirect_i) begin
                exp_v = 1'b1;
                exp_d = instr_rdata_i;
                exp_e = instr_err_i;
                exp_a = t.addr;
            end
        end
        if (redirect_i) begin
            foreach (bus_q[i]) bus_q[i].stale = 1'b1;
            if (exp_req) req_stale = 1'b1;
            model_next = {redirect_addr_i[31:2], 2'b00};
        end
        if (exp_req && instr_gnt_i) begin
            t.addr  = held_addr;
            t.stale = req_stale;
            bus_q.push_back(t);
            if (!req_stale) model_next = held_addr + 32'd4;
            held_m    = 1'b0;
            req_stale = 1'b0;
        end else if (exp_req) begin
            held_m = 1'b1;
        end
    endtask

    // Reset with rvalid noise during reset and in the release cycle.
    task automatic apply_reset(input int n);
        @(negedge clk);
        rstn        = 1'b0;
        redirect_i  = 1'b0;
        instr_gnt_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            instr_rvalid_i = 1'($urandom_range(1, 0));
            #1;
            check_val("rst_req", 32'(instr_req_o), 32'd0);
            check_val("rst_valid", 32'(out_valid_o), 32'd0);
            check_val("rst_busy", 32'(busy_o), 32'd0);
            @(negedge clk);
        end
        rstn           = 1'b1;
        instr_rvalid_i = 1'b1;
        instr_gnt_i    = 1'b1;
        fifo_free_i    = CW'(2);
        #1;
        check_val("rel_req", 32'(instr_req_o), 32'd0);
        check_val("rel_valid", 32'(out_valid_o), 32'd0);
        model_reset();
    endtask

    initial begin
        rstn            = 1'b1;
        redirect_i      = 1'b0;
        redirect_addr_i = '0;
        fifo_free_i     = '0;
        instr_gnt_i     = 1'b0;
        instr_rvalid_i  = 1'b0;
        instr_rdata_i   = '0;
        instr_err_i     = 1'b0;
        model_reset();
        #2 rstn = 1'b0;
        check_val("reset_out_addr", out_addr_o, 32'd0);
        check_val("reset_out_rdata", out_rdata_o, 32'd0);
        check_val("reset_out_err", 32'(out_err_o), 32'd0);
        apply_reset(3);

        // Streaming with full credit, zero-wait grant and 1-cycle response
        for (int i = 0; i < 40; i++) step(100, 100, 0, 2, 2);
        // No credit: no new requests
        for (int i = 0; i < 20; i++) step(50, 60, 0, 0, 0);
        // Single credit
        for (int i = 0; i < 40; i++) step(70, 50, 0, 1, 1);
        // Slow grants with frequent redirects (held-request redirect cases)
        for (int i = 0; i < 600; i++) step(25, 40, 35, 0, 3);
        // General random traffic
        for (int i = 0; i < 3000; i++) step(60, 50, 8, 0, 3);

        // Reset with requests in flight
        for (int i = 0; i < 3; i++) step(100, 0, 0, 2, 2);
        apply_reset(3);
        for (int i = 0; i < 400; i++) step(70, 60, 10, 0, 3);
        for (int i = 0; i < 200; i++) step(100, 100, 0, 2, 3);
        apply_reset(2);
        for (int i = 0; i < 20; i++) step(100, 100, 0, 2, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
